// File: rtl/uart_calc_pkg.sv
// Shared types, ASCII constants and sizing helper for the UART calculator.
// No ports; imported by the interface users, the core and the bench.
package uart_calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE, S_NUM1, S_OP, S_NUM2, S_EXEC, S_CONV, S_EMIT, S_ERR
    } state_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    // Smallest n with 10^n >= 2^rw, i.e. ceil(rw*log10 2).
    function automatic int ndig(input int rw);
        longint lim;
        longint p;
        int n;
        lim = longint'(1) << rw;
        p = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (p < lim) begin
                p = p * 10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_calc_if.sv
// Byte streams between the UART and the calculator core.
// rx_data/rx_valid: strobe in; tx_data/tx_valid/tx_ready: valid/ready out.
interface uart_calc_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/calc_tx_fifo.sv
// DEPTH x 8 synchronous FIFO holding the reply bytes.
// Ports: push/din, pop/dout, registered full flag, empty from the count.
module calc_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          do_push;
    logic          do_pop;

    // Full is registered, so a push against a full FIFO waits a cycle
    // even if a pop frees a slot in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];
    assign count_n = count + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_calc_core.sv
// ASCII "A op B" calculator: parse, evaluate, double-dabble, emit reply.
// Ports: clk, rst, io (rx strobe in / tx valid-ready out), busy, overrun.
module uart_calc_core
    import uart_calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_calc_if.slave io,
    output logic       busy,
    output logic       overrun
);
    localparam int RW = 2 * WIDTH;
    localparam int ND = ndig(RW);
    localparam int DW = $clog2(ND);
    localparam int CW = $clog2(RW);
    localparam int BW = 4 * ND;
    localparam int XW = WIDTH + 4;

    state_t           state, state_n;
    opcode_t          op, op_n, dop;
    logic [WIDTH-1:0] acc, acc_n, a, a_n;
    logic [XW-1:0]    acc10;
    logic [RW-1:0]    bin, bin_n, alu_r, ea, eb;
    logic [BW-1:0]    bcd, bcd_n, adj;
    logic [CW-1:0]    cnt, cnt_n;
    logic [DW-1:0]    di, di_n, lead, idx;
    logic [1:0]       tail, tail_n;
    logic [3:0]       dig;
    logic [7:0]       rxb, ob;
    logic             seen, seen_n, sgn, sgn_n, lz, lz_n;
    logic             eterm, eterm_n, to_err;
    logic             alu_neg, take, is_dig, is_sp, is_term, is_op;
    logic             ovf, push, full, empty;

    assign busy = (state == S_EXEC) || (state == S_CONV) ||
                  (state == S_EMIT);
    assign take = io.rx_valid & ~busy;
    assign io.tx_valid = ~empty;

    always_comb begin
        rxb     = io.rx_data;
        is_dig  = (rxb >= CH_ZERO) && (rxb <= 8'h39);
        is_sp   = (rxb == CH_SPACE);
        is_term = (rxb == CH_EQ) || (rxb == CH_CR);
        acc10   = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) +
                  XW'(rxb[3:0]);
        ovf     = |acc10[XW-1:WIDTH];
        is_op   = 1'b1;
        dop     = OP_ADD;
        unique case (rxb)
            8'h2B:   dop = OP_ADD;
            8'h2D:   dop = OP_SUB;
            8'h2A:   dop = OP_MUL;
            8'h26:   dop = OP_AND;
            8'h7C:   dop = OP_OR;
            8'h5E:   dop = OP_XOR;
            default: is_op = 1'b0;
        endcase
    end

    // Second operand is still in acc while in EXEC.
    always_comb begin
        ea      = RW'(a);
        eb      = RW'(acc);
        alu_neg = 1'b0;
        unique case (op)
            OP_ADD: alu_r = ea + eb;
            OP_SUB: begin
                alu_neg = (a < acc);
                alu_r   = alu_neg ? (eb - ea) : (ea - eb);
            end
            OP_MUL: alu_r = ea * eb;
            OP_AND: alu_r = ea & eb;
            OP_OR:  alu_r = ea | eb;
            default: alu_r = ea ^ eb;
        endcase
    end

    // Double-dabble step, leading-digit search and reply byte select.
    always_comb begin
        for (int i = 0; i < ND; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ?
                            bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        lead = '0;
        for (int i = 1; i < ND; i++) begin
            if (bcd[4*i +: 4] != 4'd0) lead = DW'(i);
        end
        idx = lz ? lead : di;
        dig = bcd[{idx, 2'b00} +: 4];
        if (sgn)                 ob = CH_MINUS;
        else if (tail == 2'd0)   ob = (state == S_ERR) ? CH_E :
                                      CH_ZERO + {4'd0, dig};
        else if (tail == 2'd1)   ob = CH_CR;
        else                     ob = CH_LF;
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        acc_n   = acc;
        a_n     = a;
        bin_n   = bin;
        bcd_n   = bcd;
        cnt_n   = cnt;
        di_n    = di;
        tail_n  = tail;
        seen_n  = seen;
        sgn_n   = sgn;
        lz_n    = lz;
        eterm_n = eterm;
        to_err  = 1'b0;
        push    = 1'b0;
        unique case (state)
            S_IDLE: if (take && !is_sp) begin
                if (is_dig) begin
                    acc_n   = WIDTH'(rxb[3:0]);
                    state_n = S_NUM1;
                end else begin
                    to_err = 1'b1;
                end
            end
            S_NUM1, S_OP: if (take && !is_sp) begin
                if (is_dig && state == S_NUM1) begin
                    if (ovf) to_err = 1'b1;
                    else     acc_n = acc10[WIDTH-1:0];
                end else if (is_op) begin
                    a_n     = acc;
                    op_n    = dop;
                    acc_n   = '0;
                    seen_n  = 1'b0;
                    state_n = S_NUM2;
                end else begin
                    to_err = 1'b1;
                end
            end else if (take && state == S_NUM1) begin
                state_n = S_OP;
            end
            S_NUM2: if (take && !is_sp) begin
                if (is_dig) begin
                    if (ovf) to_err = 1'b1;
                    acc_n  = acc10[WIDTH-1:0];
                    seen_n = 1'b1;
                end else if (is_term && seen) begin
                    state_n = S_EXEC;
                end else begin
                    to_err = 1'b1;
                end
            end
            S_EXEC: begin
                bin_n   = alu_r;
                bcd_n   = '0;
                cnt_n   = '0;
                sgn_n   = alu_neg;
                lz_n    = 1'b1;
                tail_n  = 2'd0;
                state_n = S_CONV;
            end
            S_CONV: begin
                bcd_n = {adj[BW-2:0], bin[RW-1]};
                bin_n = {bin[RW-2:0], 1'b0};
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(RW - 1)) state_n = S_EMIT;
            end
            S_EMIT: if (!full) begin
                push = 1'b1;
                if (sgn) begin
                    sgn_n = 1'b0;
                end else if (tail == 2'd0) begin
                    if (idx == '0) tail_n = 2'd1;
                    di_n = idx - DW'(1);
                    lz_n = 1'b0;
                end else if (tail == 2'd1) begin
                    tail_n = 2'd2;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ERR: if (!eterm) begin
                if (take && is_term) eterm_n = 1'b1;
            end else if (!full) begin
                push = 1'b1;
                if (tail == 2'd2) state_n = S_IDLE;
                tail_n = tail + 2'd1;
            end
        endcase
        // The byte that trips an error may itself end the line.
        if (to_err) begin
            state_n = S_ERR;
            eterm_n = is_term;
            tail_n  = 2'd0;
            sgn_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op      <= OP_ADD;
            acc     <= '0;
            a       <= '0;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            di      <= '0;
            tail    <= '0;
            seen    <= 1'b0;
            sgn     <= 1'b0;
            lz      <= 1'b0;
            eterm   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            acc     <= acc_n;
            a       <= a_n;
            bin     <= bin_n;
            bcd     <= bcd_n;
            cnt     <= cnt_n;
            di      <= di_n;
            tail    <= tail_n;
            seen    <= seen_n;
            sgn     <= sgn_n;
            lz      <= lz_n;
            eterm   <= eterm_n;
            overrun <= io.rx_valid & busy;
        end
    end

    calc_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (ob),
        .pop   (io.tx_ready),
        .dout  (io.tx_data),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_uart_calc_core.sv
// Scoreboard bench for uart_calc_core (WIDTH=8, DEPTH=4).
// Stimulus queues expected reply bytes; a monitor pops them on tx handshakes.
module tb_uart_calc_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic overrun;

    uart_calc_if u_if();

    uart_calc_core #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (u_if),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int total = 0;
    int bad = 0;
    int ovr_cnt = 0;

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (!rst && u_if.tx_valid && u_if.tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_extra: got %h, nothing expected",
                         u_if.tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (u_if.tx_data !== mon_exp) begin
                    bad++;
                    $display("FAIL tx_byte: got %h want %h",
                             u_if.tx_data, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #2;
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
    endtask

    task automatic idle_rx();
        @(posedge clk);
        #2;
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        idle_rx();
    endtask

    task automatic expect_rsp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy || u_if.tx_valid) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d bytes still missing, want 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int lat;
        int base;
        logic got;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        u_if.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_tx_valid", u_if.tx_valid, 0);
        chk("rst_tx_data", u_if.tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        expect_rsp("46");
        for (int i = 0; i < 6; i++) begin
            string s;
            s = "12+34=";
            send_byte(s[i]);
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            u_if.rx_valid = 1'b0;
            lat++;
            got = u_if.tx_valid;
        end
        chk("latency_eq", lat, 19);
        wait_drain("drain_46");

        expect_rsp("-7");
        send_str("3 - 10\015");
        wait_drain("drain_sub");

        expect_rsp("65025");
        send_str("255*255=");
        wait_drain("drain_mul");

        expect_rsp("E");
        send_str("256+1=");
        wait_drain("drain_ovf");
        expect_rsp("2");
        send_str("1+1=");
        wait_drain("drain_after_ovf");

        expect_rsp("E");
        send_str("5?3=");
        wait_drain("drain_badop");
        expect_rsp("2");
        send_str("1+1=");
        wait_drain("drain_after_badop");

        expect_rsp("E");
        send_str("7+=");
        wait_drain("drain_nodigit");
        expect_rsp("2");
        send_str("1+1=");
        wait_drain("drain_after_nodigit");

        u_if.tx_ready = 1'b0;
        expect_rsp("10000");
        send_str("100*100=");
        repeat (30) @(posedge clk);
        #1;
        chk("stall_busy", busy, 1);
        chk("stall_valid", u_if.tx_valid, 1);
        chk("stall_head", u_if.tx_data, 32'h31);
        #2;
        u_if.tx_ready = 1'b1;
        wait_drain("drain_stall");

        base = ovr_cnt;
        expect_rsp("6");
        send_str("2*3=");
        repeat (4) @(posedge clk);
        send_byte(8'h39);
        idle_rx();
        wait_drain("drain_overrun");
        chk("overrun_pulses", ovr_cnt - base, 1);

        u_if.tx_ready = 1'b0;
        send_str("100*100=");
        repeat (30) @(posedge clk);
        #1;
        chk("pre_rst_valid", u_if.tx_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", u_if.tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        #1;
        rst = 1'b0;
        u_if.tx_ready = 1'b1;
        expect_rsp("0");
        send_str("0^0=");
        wait_drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_calc_core.md
# uart_calc_core

Parametrised command-line calculator core that sits between a byte-level UART receiver and a UART transmitter. It parses an ASCII expression of the form `A op B` followed by a terminator, evaluates it on WIDTH-bit unsigned operands with a 2·WIDTH-bit result, and converts the result to signed decimal ASCII. The reply string goes through an internal output FIFO with a valid/ready interface. This generalises the fixed 8-bit, single-digit ALU path to configurable operand width, multi-digit input and output, error reporting, and buffered back-pressure.

## Interface
- WIDTH, 8, operand width in bits, legal 4..16; result width RW = 2·WIDTH.
- DEPTH, 16, output FIFO depth in bytes, power of 2, minimum 4.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  8  received byte; valid only while rx_valid = 1.
- rx_valid  in  1  one-cycle strobe per received byte, already in the clk domain.
- tx_data  out  8  byte at the FIFO head.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  transmitter can accept; a byte pops when tx_valid & tx_ready.
- busy  out  1  high in EXEC, CONV and EMIT.
- overrun  out  1  one-cycle pulse when an rx byte is dropped because busy = 1.

## Operation
- States: IDLE, NUM1, OP, NUM2, EXEC, CONV, EMIT, ERR.
- Space (0x20) is ignored in every parse state (IDLE, NUM1, OP, NUM2).
- IDLE: a digit ('0'..'9') loads acc = digit and goes to NUM1. Any other non-space byte goes to ERR.
- NUM1 / NUM2: a digit updates acc = acc·10 + d. If the result exceeds 2^WIDTH−1, go to ERR.
- NUM1: an operator byte latches a = acc and op, and goes to NUM2 with acc cleared and a digit-seen flag cleared.
- Operators: '+' add, '-' sub, '*' mul, '&' and, '|' or, '^' xor.
- NUM2: a terminator ('=' or CR 0x0D) goes to EXEC only if at least one digit was seen; otherwise go to ERR.
- Any other byte in NUM1 or NUM2 goes to ERR.
- OP state: used when a space follows NUM1. It accepts an operator and rejects anything else.
- EXEC: r = a op b, zero-extended to RW bits.
  - Subtraction with a < b sets neg = 1 and r = b − a.
  - Multiply uses the full RW-bit product.
- CONV: double-dabble over RW cycles into NDIG BCD digits, one shift per cycle.
- EMIT: push one byte per cycle while the FIFO is not full; stall while it is full.
  - Sequence: optional '-', digits with leading zeros suppressed ('0' if r = 0), then CR, then LF.
  - Return to IDLE after the LF push.
- ERR: ignore input until a terminator, then push 'E', CR, LF (stalling when full) and return to IDLE.
- A byte arriving while busy = 1 is dropped, overrun pulses, and the state is unchanged.
- A byte arriving on the cycle EMIT completes is also dropped; the state returns to IDLE next cycle.
- FIFO behaviour:
  - Simultaneous push and pop when full: the pop frees the slot, but the push is deferred one cycle because the full flag is registered.
  - Pointers wrap modulo DEPTH. A count register distinguishes full from empty.
- Reset during any state returns to IDLE, empties the FIFO, and cancels any partially emitted reply.

## Timing
- Reset values: tx_data = 0, tx_valid = 0, busy = 0, overrun = 0; the FIFO is empty.
- rx byte accepted in the same cycle rx_valid is high; the state update is visible next cycle.
- Terminator at cycle t:
  - EXEC at t+1.
  - CONV from t+2 to t+1+RW.
  - First EMIT push at t+2+RW.
  - tx_valid rises at t+3+RW if the FIFO was empty and not stalled.
- Reply of k bytes: with the FIFO never full, the last push happens k−1 cycles after the first.
- tx_data is stable while tx_valid = 1 and tx_ready = 0.

## Structure
- Package uart_calc_pkg holds:
  - the opcode enum (ADD, SUB, MUL, AND, OR, XOR);
  - the state enum;
  - ASCII constants (SPACE, CR, LF, EQ, MINUS, 'E', '0');
  - function ndig(rw) = ceil(rw·log10 2), computed by integer loop; ndig(16) = 5.
- One sub-module, calc_tx_fifo: DEPTH×8 synchronous FIFO with push/pop, full/empty flags, and registered count.
- Parser, ALU, double-dabble and emitter live in uart_calc_core.

## Test plan
- WIDTH=8: "12+34=" → "46\r\n". Check that tx_valid rises exactly RW+3 = 19 cycles after '='.
- WIDTH=8: "3 - 10\r" → "-7\r\n". WIDTH=8: "255*255=" → "65025\r\n".
- WIDTH=8: "256+1=" → "E\r\n". "5?3=" → "E\r\n". "7+=" → "E\r\n". After each, "1+1=" → "2\r\n".
- DEPTH=4, tx_ready held low through a "100*100=" reply, then released: received bytes are "10000\r\n" with no loss or duplication; EMIT stalls while full.
- Send a digit during CONV: overrun pulses once, and the reply for the in-flight expression is unaffected.
- Assert rst mid-EMIT: FIFO empty, tx_valid = 0 next cycle, and the next "0^0=" returns "0\r\n".
